psum_drain: RTL and testbench

PSUM_DRAIN -- requirements
Module: psum_drain

---
 rtl/tpu_pkg.sv | 13 +
 rtl/psum_sat.sv | 33 +++
 rtl/psum_drain.sv | 103 ++++++++++
 tb/tb_psum_drain.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared TPU constants: accumulator width, saturation width,
// and the partial-sum drain state encoding.
package tpu_pkg;

  localparam int ACC_W = 34;
  localparam int SAT_W = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/psum_sat.sv
// psum_sat: clamps a signed W-bit value to the signed SAT_W range.
// Ports: din (W-bit signed row), dout (saturated, sign-extended to W).
module psum_sat
  import tpu_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int TW = W - SAT_W + 1;

  // Value fits when every bit from the sign bit down to bit SAT_W-1
  // agrees; otherwise clamp toward the side the sign bit points to.
  logic [TW-1:0] top;
  logic          fits;

  assign top  = din[W-1:SAT_W-1];
  assign fits = (&top) | ~(|top);

  always_comb begin
    dout = din;
    if (!fits) begin
      if (din[W-1]) begin
        dout = {{TW{1'b1}}, {(SAT_W-1){1'b0}}};
      end else begin
        dout = {{TW{1'b0}}, {(SAT_W-1){1'b1}}};
      end
    end
  end

endmodule

// File: rtl/psum_drain.sv
// psum_drain: captures ROWS partial sums and drains them one row per
// valid/ready handshake.
// Ports: C clk, R sync active-high reset, load/D capture request and
// rows, busy, out_valid/out_ready/out_data/out_idx/out_last stream,
// ovr sticky dropped-load flag.
// Option: define PSUM_DRAIN_SAT_EN to saturate rows to signed 32 bits.
module psum_drain
  import tpu_pkg::*;
#(
  parameter  int ROWS = 8,
  parameter  int W    = ACC_W,
  localparam int IW   = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            C,
  input  logic            R,
  input  logic            load,
  input  logic [ROWS*W-1:0] D,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output logic [IW-1:0]   out_idx,
  output logic            out_last,
  output logic            ovr
);

  localparam logic [IW-1:0] LAST = IW'(ROWS - 1);

  drain_state_e  state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          ovr_q, ovr_d;
  logic [W-1:0]  shadow_q [ROWS];
  logic [W-1:0]  shadow_d [ROWS];
  logic [W-1:0]  row;

  assign busy      = (state_q == DRAIN);
  assign out_valid = busy;
  assign out_idx   = idx_q;
  assign out_last  = (idx_q == LAST);
  assign ovr       = ovr_q;
  assign row       = shadow_q[idx_q];

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    ovr_d    = ovr_q;
    shadow_d = shadow_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          for (int i = 0; i < ROWS; i++) begin
            shadow_d[i] = D[i*W +: W];
          end
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // Any load here is dropped, including one on the final
        // handshake, which leaves one idle bubble between sets.
        if (load) begin
          ovr_d = 1'b1;
        end
        if (out_ready) begin
          if (idx_q == LAST) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        shadow_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      ovr_q    <= ovr_d;
      shadow_q <= shadow_d;
    end
  end

`ifdef PSUM_DRAIN_SAT_EN
  psum_sat #(
    .W(W)
  ) u_sat (
    .din (row),
    .dout(out_data)
  );
`else
  assign out_data = row;
`endif

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed bench for psum_drain (ROWS=4) with a
// queue-based reference model and per-cycle output comparison.
module tb_psum_drain;

  localparam int ROWS = 4;
  localparam int W    = 34;
  localparam int IW   = 2;

`ifdef PSUM_DRAIN_SAT_EN
  localparam logic [W-1:0] EXP_BIG = 34'h0_7FFF_FFFF;
  localparam logic [W-1:0] EXP_NEG = 34'h3_8000_0000;
`else
  localparam logic [W-1:0] EXP_BIG = 34'h1_0000_0000;
  localparam logic [W-1:0] EXP_NEG = 34'h2_0000_0000;
`endif

  logic              C = 1'b0;
  logic              R;
  logic              load;
  logic [ROWS*W-1:0] D;
  logic              busy;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_data;
  logic [IW-1:0]     out_idx;
  logic              out_last;
  logic              ovr;

  int vectors = 0;
  int fails   = 0;
  bit chk_en  = 1'b0;
  int nrows;

  psum_drain #(
    .ROWS(ROWS),
    .W   (W)
  ) dut (
    .C        (C),
    .R        (R),
    .load     (load),
    .D        (D),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .ovr      (ovr)
  );

  always #5 C = ~C;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge C);
    #1;
  endtask

  task automatic set_rows(input longint r0, input longint r1,
                          input longint r2, input longint r3);
    D[0*W +: W] = W'(r0);
    D[1*W +: W] = W'(r1);
    D[2*W +: W] = W'(r2);
    D[3*W +: W] = W'(r3);
  endtask

  // Expected output word from a stored row, using signed arithmetic.
  function automatic logic [W-1:0] exp_out(input logic [W-1:0] r);
`ifdef PSUM_DRAIN_SAT_EN
    longint      v;
    logic [63:0] t;
    v = longint'({{(64-W){r[W-1]}}, r});
    if (v > 64'sd2147483647) v = 64'sd2147483647;
    if (v < -64'sd2147483648) v = -64'sd2147483648;
    t = v;
    return t[W-1:0];
`else
    return r;
`endif
  endfunction

  // Reference model: rows still owed to the consumer, in order.
  logic [W-1:0] pend [$];
  int           m_idx = 0;
  bit           m_ovr = 1'b0;

  initial begin
    forever begin
      @(posedge C);
      if (R) begin
        pend.delete();
        m_idx = 0;
        m_ovr = 1'b0;
      end else if (pend.size() == 0) begin
        if (load) begin
          for (int i = 0; i < ROWS; i++) pend.push_back(D[i*W +: W]);
          m_idx = 0;
        end
      end else begin
        if (load) m_ovr = 1'b1;
        if (out_ready) begin
          void'(pend.pop_front());
          m_idx = (pend.size() == 0) ? 0 : m_idx + 1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge C);
      if (chk_en) begin
        chk("m_valid", 64'(out_valid), 64'(pend.size() != 0));
        chk("m_busy", 64'(busy), 64'(pend.size() != 0));
        chk("m_ovr", 64'(ovr), 64'(m_ovr));
        chk("m_idx", 64'(out_idx), 64'(m_idx));
        if (pend.size() != 0) begin
          chk("m_data", 64'(out_data), 64'(exp_out(pend[0])));
          chk("m_last", 64'(out_last), 64'(pend.size() == 1));
        end
      end
    end
  end

  initial begin
    R = 1'b1; load = 1'b0; out_ready = 1'b0; D = '0;
    cyc();
    chk_en = 1'b1;
    R = 1'b0;
    cyc();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_idx", 64'(out_idx), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_ovr", 64'(ovr), 64'd0);

    // basic drain
    set_rows(5, -3, 64'h1_0000_0000, 7);
    load = 1'b1; out_ready = 1'b1;
    cyc();
    load = 1'b0;
    chk("b_d0", 64'(out_data), 64'd5);
    chk("b_i0", 64'(out_idx), 64'd0);
    chk("b_l0", 64'(out_last), 64'd0);
    cyc();
    chk("b_d1", 64'(out_data), 64'h3_FFFF_FFFD);
    cyc();
    chk("b_d2", 64'(out_data), 64'(EXP_BIG));
    cyc();
    chk("b_i3", 64'(out_idx), 64'd3);
    chk("b_l3", 64'(out_last), 64'd1);
    cyc();
    chk("b_busy6", 64'(busy), 64'd0);

    // backpressure at idx 1
    set_rows(11, 22, 33, 44);
    load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    out_ready = 1'b0;
    repeat (3) begin
      cyc();
      chk("bp_i1", 64'(out_idx), 64'd1);
      chk("bp_d1", 64'(out_data), 64'd22);
    end
    out_ready = 1'b1;
    cyc();
    chk("bp_i2", 64'(out_idx), 64'd2);
    chk("bp_d2", 64'(out_data), 64'd33);
    cyc();
    cyc();
    chk("bp_done", 64'(busy), 64'd0);

    // overrun during idx 2
    set_rows(64'h2_0000_0000, 1, 2, 3);
    load = 1'b1;
    cyc();
    load = 1'b0;
    chk("o_d0", 64'(out_data), 64'(EXP_NEG));
    cyc();
    cyc();
    set_rows(9, 9, 9, 9);
    out_ready = 1'b0; load = 1'b1;
    cyc();
    load = 1'b0;
    chk("o_d2", 64'(out_data), 64'd2);
    chk("o_ovr", 64'(ovr), 64'd1);
    out_ready = 1'b1;
    cyc();
    chk("o_d3", 64'(out_data), 64'd3);
    cyc();
    chk("o_idle", 64'(busy), 64'd0);
    chk("o_sticky", 64'(ovr), 64'd1);
    R = 1'b1;
    cyc();
    R = 1'b0;
    chk("o_clr", 64'(ovr), 64'd0);

    // load coinciding with final handshake
    set_rows(1, 2, 3, 4);
    load = 1'b1;
    cyc();
    load = 1'b0;
    cyc(); cyc(); cyc();
    chk("f_last", 64'(out_last), 64'd1);
    load = 1'b1;
    cyc();
    load = 1'b0;
    chk("f_busy", 64'(busy), 64'd0);
    chk("f_ovr", 64'(ovr), 64'd1);
    cyc();
    chk("f_drop", 64'(busy), 64'd0);

    // reset mid-drain, with load and handshake in the same cycle
    R = 1'b1;
    cyc();
    R = 1'b0;
    set_rows(50, 51, 52, 53);
    load = 1'b1;
    cyc();
    load = 1'b0;
    cyc();
    chk("r_i1", 64'(out_idx), 64'd1);
    R = 1'b1; load = 1'b1;
    cyc();
    R = 1'b0; load = 1'b0;
    chk("r_valid", 64'(out_valid), 64'd0);
    chk("r_busy", 64'(busy), 64'd0);
    chk("r_idx", 64'(out_idx), 64'd0);
    chk("r_ovr", 64'(ovr), 64'd0);
    cyc();
    chk("r_quiet", 64'(out_valid), 64'd0);
    set_rows(100, 101, 102, 103);
    load = 1'b1;
    cyc();
    load = 1'b0;
    chk("r_d0", 64'(out_data), 64'd100);
    chk("r_i0", 64'(out_idx), 64'd0);
    repeat (4) cyc();
    chk("r_done", 64'(busy), 64'd0);

    // streaming: load held high for three sets
    R = 1'b1;
    cyc();
    R = 1'b0;
    nrows = 0;
    out_ready = 1'b1; load = 1'b1;
    for (int k = 0; k < 15; k++) begin
      set_rows(1000 + k*4, 1001 + k*4, 1002 + k*4, 1003 + k*4);
      cyc();
      if (out_valid) nrows++;
    end
    load = 1'b0;
    chk("s_rows", 64'(nrows), 64'd12);
    chk("s_ovr", 64'(ovr), 64'd1);
    cyc();
    chk("s_idle", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
